// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the buffered UART transmitter.
//                Holds the transmitter FSM state encoding and the data width.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Transmitter frame phases; width fixed at 2 bits so the encoding is explicit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam int UART_DATA_BITS = 8;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous byte FIFO with registered occupancy count and
//                show-ahead read (rdata always presents the oldest entry).
//  Ports       : soc_clk    - clock, all logic on posedge
//                soc_areset - asynchronous active-high reset (flushes FIFO)
//                push/wdata - write strobe and data (ignored when full)
//                pop        - read strobe (ignored when empty)
//                rdata      - oldest entry, valid whenever empty=0
//                count      - number of stored entries
//                full/empty - occupancy flags derived from count
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          soc_clk,
  input  logic                          soc_areset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic [AW:0]           count_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge soc_clk or posedge soc_areset) begin
    if (soc_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge soc_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : uart_tx_fifo

`default_nettype wire

// File: rtl/uart_tx_stim.sv
// ============================================================================
//  Module      : uart_tx_stim
//  Description : Buffered 8N1/8N2 UART transmitter. Bytes accepted on a
//                valid/ready port are queued and sent LSB-first on tx.
//  Ports       : soc_clk    - clock, all logic on posedge
//                soc_areset - asynchronous active-high reset
//                in_valid   - byte offered
//                in_data    - byte to send (sampled only on transfer)
//                in_ready   - FIFO can accept a byte
//                tx         - registered serial line, idle high
//                busy       - frame in progress or FIFO non-empty
//                fifo_count - bytes queued, excluding the frame in flight
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          soc_clk,
  input  logic                          soc_areset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_e    state_q;
  uart_tx_state_e    state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_q;
  logic [2:0]        bit_d;
  logic              stop_q;
  logic              stop_d;
  logic [7:0]        shreg_q;
  logic [7:0]        shreg_d;
  logic              tx_q;
  logic              tx_d;
  logic              ready_en_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              baud_done;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .soc_clk    (soc_clk),
    .soc_areset (soc_areset),
    .push       (fifo_push),
    .wdata      (in_data),
    .pop        (fifo_pop),
    .rdata      (fifo_rdata),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // ready_en_q holds in_ready low through reset and for no longer than the
  // first edge after release. No bypass: a pop does not open a full FIFO.
  assign in_ready  = ready_en_q & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign baud_done = (baud_q == BAUD_LAST);
  assign tx        = tx_q;

  // State register and datapath registers.
  always_ff @(posedge soc_clk or posedge soc_areset) begin
    if (soc_areset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (baud_done) state_d = DATA;
      DATA:    if (baud_done && (bit_q == BIT_LAST)) state_d = STOP;
      STOP:    if (baud_done && (stop_q == STOP_LAST))
                 state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. tx_d is the line level for the next bit
  // period, so every phase change registers its new level at the same edge.
  always_comb begin
    fifo_pop = 1'b0;
    baud_d   = baud_q + BAUD_ONE;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d = '0;
          bit_d  = '0;
          tx_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            stop_d = 1'b0;
            tx_d   = 1'b1;
          end else begin
            // shreg_q[1] is the bit that lands in shreg_q[0] after the shift.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_rdata;
              tx_d     = 1'b0;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        baud_d = '0;
        tx_d   = 1'b1;
      end
    endcase
  end

  assign busy = (state_q != IDLE) | (fifo_count != '0);

endmodule : uart_tx_stim

`default_nettype wire

// File: tb/tb_uart_tx_stim.sv
// ============================================================================
//  Module      : tb_uart_tx_stim
//  Description : Directed self-checking bench for uart_tx_stim. Two DUTs:
//                u_dut1 with one stop bit, u_dut2 with two stop bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_stim;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  logic       v2;
  logic [7:0] d2;
  logic       r2;
  logic       tx2;
  logic       busy2;
  logic [2:0] cnt2;

  int checks   = 0;
  int failures = 0;

  logic wave [0:299];

  always #5 clk = ~clk;

  uart_tx_stim #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) u_dut1 (
    .soc_clk(clk), .soc_areset(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_stim #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
    .soc_clk(clk), .soc_areset(rst), .in_valid(v2), .in_data(d2),
    .in_ready(r2), .tx(tx2), .busy(busy2), .fifo_count(cnt2)
  );

  // Expected line level i cycles after a frame's falling edge.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    int k;
    k = i / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Receiver model: sample mid-bit of the frame starting at wave[p].
  function automatic logic [7:0] rx_byte(input int p);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = wave[p + CPB*(b+1) + CPB/2];
    return v;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (tx2 !== 1'b1) begin failures++; $display("FAIL reset_tx2 got=%b exp=1", tx2); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge got=%b exp=1", in_ready); end
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_at_accept got=%b exp=1", tx); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      wave[i] = tx;
      if (i == 39) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_stop got=%b exp=1", busy); end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (wave[i] !== exp_bit(8'hA5, i)) begin
        failures++; $display("FAIL single_wave[%0d] got=%b exp=%b", i, wave[i], exp_bit(8'hA5, i));
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_tx_idle got=%b exp=1", tx); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bb [3];
    logic [7:0] got;
    bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h55;
    for (int t = 0; t < 122; t++) begin
      in_valid = (t < 3);
      if (t < 3) in_data = bb[t];
      if (t >= 2) wave[t-2] = tx;
      @(negedge clk);
    end
    for (int i = 0; i < 120; i++) begin
      checks++;
      if (wave[i] !== exp_bit(bb[i/40], i % 40)) begin
        failures++; $display("FAIL b2b_wave[%0d] got=%b exp=%b", i, wave[i], exp_bit(bb[i/40], i % 40));
      end
    end
    for (int j = 0; j < 3; j++) begin
      got = rx_byte(j*40);
      checks++; if (got !== bb[j]) begin failures++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", j, got, bb[j]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure;
    logic [7:0] bb [6];
    logic [7:0] got;
    logic       xfer;
    int         idx;
    int         t_drop;
    int         t_rise;
    int         cnt_at_drop;
    bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33; bb[3] = 8'h44; bb[4] = 8'h5A; bb[5] = 8'hC6;
    idx = 0; t_drop = -1; t_rise = -1; cnt_at_drop = -1;
    for (int t = 0; t < 243; t++) begin
      if (t >= 2) wave[t-2] = tx;
      if (t_drop < 0 && !in_ready) begin
        t_drop = t; cnt_at_drop = int'(fifo_count);
      end else if (t_drop >= 0 && t_rise < 0 && in_ready) begin
        t_rise = t;
      end
      in_valid = (idx < 6);
      if (idx < 6) in_data = bb[idx];
      xfer = in_valid & in_ready;
      @(negedge clk);
      if (xfer) idx++;
    end
    in_valid = 1'b0;
    checks++; if (t_drop !== 5) begin failures++; $display("FAIL bp_drop_cycle got=%0d exp=5", t_drop); end
    checks++; if (cnt_at_drop !== 4) begin failures++; $display("FAIL bp_drop_count got=%0d exp=4", cnt_at_drop); end
    checks++; if (t_rise !== 42) begin failures++; $display("FAIL bp_rise_cycle got=%0d exp=42", t_rise); end
    checks++; if (idx !== 6) begin failures++; $display("FAIL bp_accepted got=%0d exp=6", idx); end
    for (int j = 0; j < 6; j++) begin
      got = rx_byte(j*40);
      checks++; if (got !== bb[j]) begin failures++; $display("FAIL bp_rx[%0d] got=%h exp=%h", j, got, bb[j]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_full_pop;
    logic [7:0] bb [5];
    int         waited;
    bb[0] = 8'h01; bb[1] = 8'h02; bb[2] = 8'h03; bb[3] = 8'h04; bb[4] = 8'h05;
    for (int t = 0; t < 44; t++) begin
      in_valid = 1'b1;
      in_data  = (t < 5) ? bb[t] : 8'h99;
      if (t == 41) begin
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fp_count_full got=%0d exp=4", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fp_ready_on_pop got=%b exp=0", in_ready); end
      end
      if (t == 42) begin
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL fp_count_after_pop got=%0d exp=3", fifo_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fp_ready_after_pop got=%b exp=1", in_ready); end
      end
      if (t == 43) begin
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fp_count_refill got=%0d exp=4", fifo_count); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    waited = 0;
    while (busy && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fp_drain_timeout got_busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_midframe;
    int lows;
    int busy_hi;
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_data = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    // Now at the first start-bit sample; bit 3 spans samples 16..19.
    repeat (17) @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL mr_count_before got=%0d exp=1", fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mr_tx got=%b exp=1", tx); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL mr_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lows = 0; busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busy_hi++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL mr_no_frame got_low_cycles=%0d exp=0", lows); end
    checks++; if (busy_hi !== 0) begin failures++; $display("FAIL mr_idle got_busy_cycles=%0d exp=0", busy_hi); end
  endtask

  task automatic test_two_stop;
    logic [7:0] bb [2];
    logic [7:0] got;
    int         stop_hi;
    bb[0] = 8'h81; bb[1] = 8'h42;
    for (int t = 0; t < 90; t++) begin
      v2 = (t < 2);
      if (t < 2) d2 = bb[t];
      if (t >= 2) wave[t-2] = tx2;
      @(negedge clk);
    end
    for (int i = 0; i < 88; i++) begin
      checks++;
      if (wave[i] !== exp_bit(bb[i/44], i % 44)) begin
        failures++; $display("FAIL s2_wave[%0d] got=%b exp=%b", i, wave[i], exp_bit(bb[i/44], i % 44));
      end
    end
    stop_hi = 0;
    for (int i = 36; i < 44; i++) if (wave[i] === 1'b1) stop_hi++;
    checks++; if (stop_hi !== 8) begin failures++; $display("FAIL s2_stop_len got=%0d exp=8", stop_hi); end
    checks++; if (wave[44] !== 1'b0) begin failures++; $display("FAIL s2_second_start got=%b exp=0", wave[44]); end
    for (int j = 0; j < 2; j++) begin
      got = rx_byte(j*44);
      checks++; if (got !== bb[j]) begin failures++; $display("FAIL s2_rx[%0d] got=%h exp=%h", j, got, bb[j]); end
    end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL s2_busy_end got=%b exp=0", busy2); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; v2 = 1'b0; d2 = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_pop();
    test_reset_midframe();
    test_two_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx_stim

`default_nettype wire
